// File: rtl/isp_awb.sv
// Gray-world auto white balance: per-frame R/G/B statistics, R/B gain division
// during vertical blanking, and a 2-cycle gain application pipeline.
module isp_awb #(
    parameter int BITS      = 8,
    parameter int WIDTH     = 256,
    parameter int HEIGHT    = 10,
    parameter int GAIN_FRAC = 6
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            awb_en,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_r,
    input  logic [BITS-1:0] in_g,
    input  logic [BITS-1:0] in_b,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_r,
    output logic [BITS-1:0] out_g,
    output logic [BITS-1:0] out_b,
    output logic [7:0]      gain_r_o,
    output logic [7:0]      gain_b_o,
    output logic            stat_valid
);

    localparam int SUM_W = BITS + $clog2(WIDTH * HEIGHT) + 1;
    localparam int DIV_W = SUM_W + 8;
    localparam int PW    = BITS + 8;
    localparam int SW    = PW + 1;
    localparam logic [7:0] UNITY = 8'(1 << GAIN_FRAC);

    typedef enum logic [2:0] {IDLE, CHK_R, DIV_R, CHK_B, DIV_B, UPDATE} state_t;

    state_t             state, state_nxt;
    logic               vsync_d, armed, rise, fall, start;
    logic [SUM_W-1:0]   sum_r, sum_g, sum_b, snap_r, snap_g, snap_b, den;
    logic [DIV_W-1:0]   rem, dvs;
    logic [7:0]         quot, quot_nxt, q_r;
    logic [2:0]         bit_cnt;
    logic               skip;
    logic [7:0]         applied_r, applied_b, sel_r, sel_b;
    logic [PW-1:0]      p_r, p_b;
    logic [BITS-1:0]    g_d1;
    logic               href_d1, vsync_d1;

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [BITS-1:0]  b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {{(SUM_W + 1 - BITS){1'b0}}, b};
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    function automatic logic [BITS-1:0] round_clamp(input logic [PW-1:0] p);
        logic [SW-1:0] s;
        s = ({1'b0, p} + SW'(1 << (GAIN_FRAC - 1))) >> GAIN_FRAC;
        return (s > SW'({BITS{1'b1}})) ? '1 : s[BITS-1:0];
    endfunction

    assign rise  = in_vsync & ~vsync_d;
    assign fall  = ~in_vsync & vsync_d;
    assign start = fall & armed & (state == IDLE);

    // vsync_d resets high so a frame already in progress at release is not seen as a rise
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b1;
            armed   <= 1'b0;
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
        end else begin
            vsync_d <= in_vsync;
            if (rise)
                armed <= 1'b1;
            if (fall) begin
                sum_r <= '0;
                sum_g <= '0;
                sum_b <= '0;
            end else if (armed && in_vsync && in_href) begin
                sum_r <= sat_add(sum_r, in_r);
                sum_g <= sat_add(sum_g, in_g);
                sum_b <= sat_add(sum_b, in_b);
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            snap_r <= '0;
            snap_g <= '0;
            snap_b <= '0;
        end else if (start) begin
            snap_r <= sum_r;
            snap_g <= sum_g;
            snap_b <= sum_b;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CHK_R;
            CHK_R:   state_nxt = DIV_R;
            DIV_R:   if (bit_cnt == 3'd7) state_nxt = CHK_B;
            CHK_B:   state_nxt = DIV_B;
            DIV_B:   if (bit_cnt == 3'd7) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign den      = (state == CHK_B) ? snap_b : snap_r;
    assign quot_nxt = skip ? quot : {quot[6:0], (rem >= dvs)};

    // Quotient is < 256 whenever the divide runs, so the divisor starts at den<<7
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            rem        <= '0;
            dvs        <= '0;
            quot       <= UNITY;
            skip       <= 1'b0;
            q_r        <= UNITY;
            gain_r_o   <= UNITY;
            gain_b_o   <= UNITY;
            stat_valid <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            case (state)
                CHK_R, CHK_B: begin
                    bit_cnt <= '0;
                    rem     <= DIV_W'(snap_g) << GAIN_FRAC;
                    dvs     <= DIV_W'(den) << 7;
                    if (den == '0) begin
                        skip <= 1'b1;
                        quot <= UNITY;
                    end else if ({2'b00, snap_g} >= {den, 2'b00}) begin
                        skip <= 1'b1;
                        quot <= 8'hFF;
                    end else begin
                        skip <= 1'b0;
                        quot <= '0;
                    end
                end
                DIV_R, DIV_B: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    quot    <= quot_nxt;
                    dvs     <= dvs >> 1;
                    if (!skip && rem >= dvs)
                        rem <= rem - dvs;
                    if (state == DIV_R && bit_cnt == 3'd7)
                        q_r <= quot_nxt;
                end
                UPDATE: begin
                    gain_r_o   <= q_r;
                    gain_b_o   <= quot;
                    stat_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            applied_r <= UNITY;
            applied_b <= UNITY;
        end else if (rise) begin
            applied_r <= gain_r_o;
            applied_b <= gain_b_o;
        end
    end

    assign sel_r = awb_en ? applied_r : UNITY;
    assign sel_b = awb_en ? applied_b : UNITY;

    // G has a fixed unity gain, which is an exact pass-through, so it is only delayed
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            p_r       <= '0;
            p_b       <= '0;
            g_d1      <= '0;
            href_d1   <= 1'b0;
            vsync_d1  <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_href  <= 1'b0;
            out_vsync <= 1'b0;
        end else begin
            p_r       <= PW'(in_r) * PW'(sel_r);
            p_b       <= PW'(in_b) * PW'(sel_b);
            g_d1      <= in_g;
            href_d1   <= in_href;
            vsync_d1  <= in_vsync;
            out_r     <= round_clamp(p_r);
            out_g     <= g_d1;
            out_b     <= round_clamp(p_b);
            out_href  <= href_d1;
            out_vsync <= vsync_d1;
        end
    end

endmodule

// File: tb/tb_isp_awb.sv
// Directed + randomized bench for isp_awb against a frame-level gray-world model.
module tb_isp_awb;

    logic       pclk = 1'b0;
    logic       rst, awb_en, in_href, in_vsync;
    logic [7:0] in_r, in_g, in_b;
    logic       out_href, out_vsync, stat_valid;
    logic [7:0] out_r, out_g, out_b, gain_r_o, gain_b_o;

    always #5 pclk = ~pclk;

    isp_awb dut (
        .pclk(pclk), .rst(rst), .awb_en(awb_en),
        .in_href(in_href), .in_vsync(in_vsync),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_href(out_href), .out_vsync(out_vsync),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .gain_r_o(gain_r_o), .gain_b_o(gain_b_o), .stat_valid(stat_valid)
    );

    int vectors = 0, miscompares = 0;

    int     armed_m, busy_cnt, prev_vs, sv_exp;
    longint sr, sg, sb;
    int     gain_r_m, gain_b_m, pend_r, pend_b, app_r_m, app_b_m;
    int     ep_r, ep_g, ep_b, ep_href, ep_vs;
    int     cyc = 0, fall_cyc = 0, sv_count = 0;
    int     last_r, last_g, last_b, last_in_r, last_in_g, last_in_b;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_gain(input longint s, input longint g);
        if (s == 0) return 64;
        if (g >= 4 * s) return 255;
        return int'((g * 64) / s);
    endfunction

    function automatic int px(input int v, input int gain);
        int t;
        t = (v * gain + 32) / 64;
        return (t > 255) ? 255 : t;
    endfunction

    function automatic int pix(input int base, input int nz);
        int v;
        if (base < 0) return int'($urandom_range(0, 255));
        v = base + int'($urandom_range(0, nz));
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        armed_m = 0; busy_cnt = 0; prev_vs = 1; sv_exp = 0;
        sr = 0; sg = 0; sb = 0;
        gain_r_m = 64; gain_b_m = 64; app_r_m = 64; app_b_m = 64;
        ep_r = 0; ep_g = 0; ep_b = 0; ep_href = 0; ep_vs = 0;
    endtask

    // One pixel clock: drive, advance past the edge, update the model, compare
    task automatic apply_stimulus(input int href, input int vs, input int r, input int g, input int b);
        int  nr, ng, nb;
        bit  rise, fall, was_busy;
        in_href  = 1'(href);
        in_vsync = 1'(vs);
        in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
        nr = px(r, awb_en ? app_r_m : 64);
        ng = g;
        nb = px(b, awb_en ? app_b_m : 64);
        @(posedge pclk);
        #1;
        cyc++;
        rise = (vs != 0) && (prev_vs == 0);
        fall = (vs == 0) && (prev_vs != 0);
        prev_vs = vs;
        if (rise) begin
            app_r_m = gain_r_m;
            app_b_m = gain_b_m;
        end
        sv_exp = 0;
        was_busy = (busy_cnt != 0);
        if (was_busy) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                gain_r_m = pend_r;
                gain_b_m = pend_b;
                sv_exp = 1;
            end
        end
        if (fall) begin
            if (armed_m != 0 && !was_busy) begin
                pend_r = model_gain(sr, sg);
                pend_b = model_gain(sb, sg);
                busy_cnt = 19;
                fall_cyc = cyc;
            end
            sr = 0; sg = 0; sb = 0;
        end else if (armed_m != 0 && vs != 0 && href != 0) begin
            sr += r; sg += g; sb += b;
        end
        if (rise) armed_m = 1;

        check_output("out_r", out_r, ep_r);
        check_output("out_g", out_g, ep_g);
        check_output("out_b", out_b, ep_b);
        check_output("out_href", out_href, ep_href);
        check_output("out_vsync", out_vsync, ep_vs);
        check_output("gain_r_o", gain_r_o, gain_r_m);
        check_output("gain_b_o", gain_b_o, gain_b_m);
        check_output("stat_valid", stat_valid, sv_exp);
        if (stat_valid) begin
            sv_count++;
            check_output("stat_latency", cyc - fall_cyc, 19);
        end
        if (out_href) begin
            last_r = out_r; last_g = out_g; last_b = out_b;
        end
        if (href != 0) begin
            last_in_r = r; last_in_g = g; last_in_b = b;
        end
        ep_r = nr; ep_g = ng; ep_b = nb; ep_href = href; ep_vs = vs;
    endtask

    task automatic run_stream(input int n, input int vs);
        for (int i = 0; i < n; i++)
            apply_stimulus(((i % 4) != 0 && vs != 0) ? 1 : 0, vs,
                           pix(-1, 0), pix(-1, 0), pix(-1, 0));
    endtask

    // Full frame: 2 lead-in cycles, 10 lines of 256 pixels + 4 blank, then vblank
    task automatic apply_frame(input int cr, input int cg, input int cb, input int nz, input int vblank);
        for (int i = 0; i < 2; i++)
            apply_stimulus(0, 1, pix(-1, 0), pix(-1, 0), pix(-1, 0));
        for (int l = 0; l < 10; l++) begin
            for (int p = 0; p < 256; p++)
                apply_stimulus(1, 1, pix(cr, nz), pix(cg, nz), pix(cb, nz));
            for (int h = 0; h < 4; h++)
                apply_stimulus(0, 1, pix(-1, 0), pix(-1, 0), pix(-1, 0));
        end
        if (vblank > 0) run_stream(vblank, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_out_r"}, out_r, 0);
        check_output({tag, "_out_g"}, out_g, 0);
        check_output({tag, "_out_b"}, out_b, 0);
        check_output({tag, "_href"}, out_href, 0);
        check_output({tag, "_vsync"}, out_vsync, 0);
        check_output({tag, "_gain_r"}, gain_r_o, 64);
        check_output({tag, "_gain_b"}, gain_b_o, 64);
        check_output({tag, "_stat"}, stat_valid, 0);
    endtask

    initial begin
        rst = 1'b1; awb_en = 1'b1; in_href = 1'b0; in_vsync = 1'b0;
        in_r = '0; in_g = '0; in_b = '0;
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        check_reset_state("por");
        rst = 1'b0;

        // Reset mid-frame: that frame must never produce statistics
        run_stream(20, 0);
        run_stream(300, 1);
        #3 rst = 1'b1;
        #1 check_reset_state("mid_rst");
        @(posedge pclk);
        #1;
        rst = 1'b0;
        model_reset();
        run_stream(500, 1);
        run_stream(30, 0);
        check_output("no_stat_after_rst", sv_count, 0);
        apply_frame(-1, -1, -1, 0, 30);
        check_output("stat_first_frame", sv_count, 1);

        // Neutral frames
        apply_frame(100, 100, 100, 0, 30);
        check_output("neutral_gain_r", gain_r_o, 64);
        check_output("neutral_gain_b", gain_b_o, 64);
        apply_frame(100, 100, 100, 0, 30);
        check_output("neutral_out_r", last_r, 100);
        check_output("neutral_out_b", last_b, 100);

        // Colour cast
        apply_frame(50, 100, 200, 0, 30);
        check_output("cast_gain_r", gain_r_o, 128);
        check_output("cast_gain_b", gain_b_o, 32);
        check_output("cast_cur_r", last_r, 50);
        check_output("cast_cur_b", last_b, 200);
        apply_frame(50, 100, 200, 0, 30);
        check_output("cast_next_r", last_r, 100);
        check_output("cast_next_g", last_g, 100);
        check_output("cast_next_b", last_b, 100);

        // Saturated gain and clamped output
        apply_frame(20, 100, 100, 0, 30);
        check_output("sat_gain_r", gain_r_o, 255);
        apply_frame(200, 100, 100, 0, 30);
        check_output("sat_out_r", last_r, 255);

        // Zero red sum, then bypass with non-unity gains pending
        apply_frame(0, 100, 100, 0, 30);
        check_output("zero_gain_r", gain_r_o, 64);
        apply_frame(50, 100, 200, 0, 30);
        awb_en = 1'b0;
        apply_frame(-1, -1, -1, 0, 30);
        check_output("bypass_r", last_r, last_in_r);
        check_output("bypass_g", last_g, last_in_g);
        check_output("bypass_b", last_b, last_in_b);

        // Short vblank: gains from frame A land only on the frame after B
        awb_en = 1'b1;
        apply_frame(50, 100, 200, 0, 5);
        apply_frame(-1, -1, -1, 0, 0);
        check_output("short_vb_gain_r", gain_r_o, 128);
        check_output("short_vb_gain_b", gain_b_o, 32);
        run_stream(30, 0);
        apply_frame(100, 100, 100, 0, 30);

        // Randomized casts, noise, vblank length and enable
        for (int k = 0; k < 3; k++) begin
            awb_en = 1'($urandom_range(0, 1));
            apply_frame(int'($urandom_range(10, 240)), int'($urandom_range(10, 240)),
                        int'($urandom_range(10, 240)), 15, int'($urandom_range(5, 40)));
        end
        run_stream(10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
